// File: rtl/ulpi_rx_capture_if.sv
// ulpi_rx_capture_if: ULPI receive pins plus the downstream fifo_stack and
// status signals for ulpi_rx_capture. slave = capture block, master = PHY/sink side.
interface ulpi_rx_capture_if;
  logic       en;
  logic [7:0] DATA;
  logic       DIR;
  logic       NXT;
  logic       STP;
  logic [7:0] fifo_din;
  logic       fifo_save;
  logic       FIFO_full;
  logic       pkt_end;
  logic [7:0] pkt_count;
  logic       overflow;
  logic [7:0] rx_cmd;

  modport slave (
    input  en, DATA, DIR, NXT, FIFO_full,
    output STP, fifo_din, fifo_save, pkt_end, pkt_count, overflow, rx_cmd
  );

  modport master (
    output en, DATA, DIR, NXT, FIFO_full,
    input  STP, fifo_din, fifo_save, pkt_end, pkt_count, overflow, rx_cmd
  );
endinterface

// File: rtl/ulpi_rx_capture.sv
// ulpi_rx_capture: receive-only ULPI link capture. Data bytes from the PHY go
// to fifo_stack with one cycle of latency; RX CMDs update rx_cmd and can
// close a packet. Optional feature macro ULPI_RXCMD_CAPTURE_EN: RX CMDs are
// also written to the FIFO as the pair 0xFF, <rx cmd>.
module ulpi_rx_capture #(
  parameter int MAX_PKT = 64
) (
  input  logic             i_clk_ext,
  input  logic             i_rst_n,
  ulpi_rx_capture_if.slave io_bus
);
  localparam logic [7:0] LP_MAX = 8'(MAX_PKT);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_RECV, S_TURNBACK} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_dir_q;
  logic [7:0] r_cnt;
  logic [7:0] r_din, r_pkt_count, r_rx_cmd;
  logic       r_save, r_end, r_ovf;

  logic       w_data, w_rxcmd, w_eop;
  logic       w_accept, w_ovf_data;
  logic       w_wr, w_ovf_set;
  logic [7:0] w_wr_byte;

`ifdef ULPI_RXCMD_CAPTURE_EN
  logic       r_pend_vld;
  logic [7:0] r_pend_byte;
  logic       w_pend_vld_nxt;
  logic [7:0] w_pend_byte_nxt;
`endif

  assign io_bus.STP       = 1'b0;
  assign io_bus.fifo_din  = r_din;
  assign io_bus.fifo_save = r_save;
  assign io_bus.pkt_end   = r_end;
  assign io_bus.pkt_count = r_pkt_count;
  assign io_bus.overflow  = r_ovf;
  assign io_bus.rx_cmd    = r_rx_cmd;

  // Next state and byte classification. IDLE needs a real DIR rising edge
  // (r_dir_q resets high) so a packet cut by reset is not resumed mid-stream.
  always_comb begin
    w_state_nxt = r_state;
    w_data      = 1'b0;
    w_rxcmd     = 1'b0;
    w_eop       = 1'b0;
    case (r_state)
      S_IDLE:     if (io_bus.DIR && !r_dir_q) w_state_nxt = S_TURN;
      S_TURN:     w_state_nxt = io_bus.DIR ? S_RECV : S_TURNBACK;
      S_RECV: begin
        if (!io_bus.DIR) begin
          w_state_nxt = S_TURNBACK;
          w_eop       = (r_cnt != 8'd0);
        end else if (io_bus.NXT) begin
          w_data = 1'b1;
        end else begin
          w_rxcmd = 1'b1;
          w_eop   = (r_cnt != 8'd0) && (io_bus.DATA[5:4] == 2'b00);
        end
      end
      S_TURNBACK: w_state_nxt = io_bus.DIR ? S_TURN : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO write selection. Bytes past MAX_PKT are dropped without flagging
  // overflow; only a FIFO_full drop of a byte that had room sets it.
  always_comb begin
    w_accept   = w_data && io_bus.en && !io_bus.FIFO_full && (r_cnt < LP_MAX);
    w_ovf_data = w_data && io_bus.en &&  io_bus.FIFO_full && (r_cnt < LP_MAX);
`ifdef ULPI_RXCMD_CAPTURE_EN
    w_wr            = 1'b0;
    w_wr_byte       = io_bus.DATA;
    w_ovf_set       = w_ovf_data;
    w_pend_vld_nxt  = 1'b0;
    w_pend_byte_nxt = r_pend_byte;
    if (r_pend_vld) begin
      // second half of a marker pair (or a held byte) owns this write slot;
      // an incoming data byte slides into the hold register behind it
      w_wr      = 1'b1;
      w_wr_byte = r_pend_byte;
      if (w_accept) begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_byte_nxt = io_bus.DATA;
      end
      // no room for another two-byte pair: it is lost and flagged
      if (w_rxcmd && io_bus.en) w_ovf_set = 1'b1;
    end else if (w_accept) begin
      w_wr = 1'b1;
    end else if (w_rxcmd && io_bus.en) begin
      if (io_bus.FIFO_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr            = 1'b1;
        w_wr_byte       = 8'hFF;
        w_pend_vld_nxt  = 1'b1;
        w_pend_byte_nxt = io_bus.DATA;
      end
    end
`else
    w_wr      = w_accept;
    w_wr_byte = io_bus.DATA;
    w_ovf_set = w_ovf_data;
`endif
  end

  // State, byte counter, registered FIFO strobe and status outputs.
  always_ff @(posedge i_clk_ext) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_dir_q     <= 1'b1;
      r_cnt       <= 8'd0;
      r_din       <= 8'd0;
      r_save      <= 1'b0;
      r_end       <= 1'b0;
      r_pkt_count <= 8'd0;
      r_ovf       <= 1'b0;
      r_rx_cmd    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dir_q <= io_bus.DIR;
      r_save  <= w_wr;
      r_end   <= w_eop;
      if (w_wr)      r_din       <= w_wr_byte;
      if (w_ovf_set) r_ovf       <= 1'b1;
      if (w_rxcmd)   r_rx_cmd    <= io_bus.DATA;
      if (w_eop)     r_pkt_count <= r_pkt_count + 8'd1;
      if (w_eop || w_state_nxt == S_TURN) r_cnt <= 8'd0;
      else if (w_accept)                  r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef ULPI_RXCMD_CAPTURE_EN
  // One-byte hold for the RX CMD half of a marker pair or a displaced data byte.
  always_ff @(posedge i_clk_ext) begin
    if (!i_rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_byte <= 8'd0;
    end else begin
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_byte <= w_pend_byte_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_ulpi_rx_capture.sv
// tb_ulpi_rx_capture: directed scenarios plus random ULPI traffic, checked
// every cycle against a run-length reference model of the receive protocol.
module tb_ulpi_rx_capture;
  localparam int TB_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #8 clk = ~clk;

  ulpi_rx_capture_if bus();

  ulpi_rx_capture #(.MAX_PKT(TB_MAX)) dut (
    .i_clk_ext (clk),
    .i_rst_n   (rst_n),
    .io_bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_save_seen = 0;
  int n_end_seen = 0;

  // reference model: m_pos counts cycles into a DIR-high run that began with
  // an observed rising edge (-1 = no such run); bytes at position >= 2 are received
  int         m_pos;
  logic       m_prev_dir;
  int         m_cnt;
  logic [7:0] m_pcnt, m_rx, m_din;
  logic       m_ovf;
  logic       m_exp_save, m_exp_end;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_prev_dir = 1'b1; m_cnt = 0;
    m_pcnt = 8'd0; m_rx = 8'd0; m_din = 8'd0; m_ovf = 1'b0;
    m_exp_save = 1'b0; m_exp_end = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic n, input logic [7:0] dt,
                            input logic e, input logic f);
    m_exp_save = 1'b0;
    m_exp_end  = 1'b0;
    if (m_pos >= 1) begin
      if (!d) begin
        if (m_cnt > 0) m_exp_end = 1'b1;
      end else if (n) begin
        if (e && m_cnt < TB_MAX) begin
          if (f) m_ovf = 1'b1;
          else begin m_exp_save = 1'b1; m_din = dt; m_cnt++; end
        end
      end else begin
        m_rx = dt;
        if (dt[5:4] == 2'b00 && m_cnt > 0) m_exp_end = 1'b1;
      end
    end
    if (m_exp_end) begin m_cnt = 0; m_pcnt = m_pcnt + 8'd1; end
    if (!d) m_pos = -1;
    else if (!m_prev_dir) begin m_pos = 0; m_cnt = 0; end
    else if (m_pos >= 0 && m_pos < 2) m_pos++;
    m_prev_dir = d;
  endtask

  task automatic check_outputs();
    chk("stp",       bus.STP,       1'b0);
    chk("fifo_save", bus.fifo_save, m_exp_save);
    chk("fifo_din",  bus.fifo_din,  m_din);
    chk("pkt_end",   bus.pkt_end,   m_exp_end);
    chk("pkt_count", bus.pkt_count, m_pcnt);
    chk("overflow",  bus.overflow,  m_ovf);
    chk("rx_cmd",    bus.rx_cmd,    m_rx);
    if (bus.fifo_save) n_save_seen++;
    if (bus.pkt_end)   n_end_seen++;
  endtask

  task automatic cyc(input logic d, input logic n, input logic [7:0] dt,
                     input logic e, input logic f);
    bus.DIR = d; bus.NXT = n; bus.DATA = dt; bus.en = e; bus.FIFO_full = f;
    @(posedge clk);
    model_step(d, n, dt, e, f);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic d);
    rst_n = 1'b0;
    bus.DIR = d; bus.NXT = 1'($urandom); bus.DATA = 8'($urandom);
    bus.en = 1'b1; bus.FIFO_full = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  // idle, two turnaround cycles with junk on the bus, nb data bytes, DIR low
  task automatic send_pkt(input int nb, input logic [7:0] base);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'($urandom), 8'($urandom), 1'b1, 1'b0);
    cyc(1'b1, 1'($urandom), 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < nb; i++) cyc(1'b1, 1'b1, base + 8'(i), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  int s0, e0;
  logic rdir;

  initial begin
    bus.DIR = 1'b0; bus.NXT = 1'b0; bus.DATA = 8'h00; bus.en = 1'b1; bus.FIFO_full = 1'b0;
    model_reset();
    do_reset(1'b0);

    // RX CMD then three data bytes
    s0 = n_save_seen; e0 = n_end_seen;
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h4D, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("basic_writes", n_save_seen - s0, 3);
    chk("basic_ends",   n_end_seen - e0, 1);
    chk("basic_rxcmd",  bus.rx_cmd, 8'h4D);
    chk("basic_pcnt",   bus.pkt_count, 8'd1);

    // FIFO_full on the second byte; overflow must then stick
    s0 = n_save_seen;
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hB2, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'hB3, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_writes", n_save_seen - s0, 2);
    send_pkt(2, 8'h60);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // packet longer than MAX_PKT: excess dropped silently, one pkt_end
    do_reset(1'b0);
    s0 = n_save_seen; e0 = n_end_seen;
    send_pkt(TB_MAX + 2, 8'h70);
    chk("max_writes", n_save_seen - s0, TB_MAX);
    chk("max_ends",   n_end_seen - e0, 1);
    chk("max_ovf",    bus.overflow, 1'b0);

    // RX CMD with DATA[5:4]==0 ends the packet; the later DIR fall does not
    e0 = n_end_seen;
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hC1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h0C, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("eop_once", n_end_seen - e0, 1);

    // en low mid-packet: later bytes dropped, packet still closed
    s0 = n_save_seen; e0 = n_end_seen;
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hD1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hD2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hD3, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("en_writes", n_save_seen - s0, 1);
    chk("en_ends",   n_end_seen - e0, 1);
    chk("en_ovf",    bus.overflow, 1'b0);

    // 256 single-byte packets wrap pkt_count
    do_reset(1'b0);
    e0 = n_end_seen;
    for (int p = 0; p < 256; p++) send_pkt(1, 8'(p));
    chk("wrap_ends",  n_end_seen - e0, 256);
    chk("wrap_count", bus.pkt_count, 8'd0);

    // reset during the third byte, DIR still high afterwards
    s0 = n_save_seen; e0 = n_end_seen;
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hE1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hE2, 1'b1, 1'b0);
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 8'hE4, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hE5, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hE6, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_writes", n_save_seen - s0, 2);
    chk("rst_ends",   n_end_seen - e0, 0);
    send_pkt(2, 8'hF0);
    chk("rst_next_cnt", bus.pkt_count, 8'd1);
    chk("rst_next_din", bus.fifo_din, 8'hF1);

    // random traffic with long DIR runs and rare resets
    rdir = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) rdir = ~rdir;
      if ($urandom_range(0, 799) == 0) do_reset(rdir);
      else cyc(rdir, ($urandom_range(0, 3) != 0), 8'($urandom),
               ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
